// File: rtl/led_pio_pkg.sv
// Shared definitions for the LED PIO arbiter: FSM encoding and PIO register map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_pio_pkg;

  // VERIFY is only entered when LED_PIO_ARB_VERIFY_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // The LED data register sits at offset 0 of the PIO slave.
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/led_rr_select.sv
// Round-robin pick: first set req bit searching upward from owner+1, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is used.
module led_rr_select
  import led_pio_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         owner,
  output logic [2:0]         winner,
  output logic               valid
);

  int w_dist;
  int w_best;

  // Each requester's distance past the current owner; the smallest requesting distance wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    w_dist = 0;
    w_best = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = i - int'(owner) - 1;
      if (w_dist < 0) begin
        w_dist = w_dist + NUM_REQ;
      end
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        winner = 3'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pio_arbiter.sv
// Arbitrates NUM_REQ LED writers onto one PIO slave; optional readback check (LED_PIO_ARB_VERIFY_EN).
// Latency: req seen in IDLE at N -> write strobe N+1 -> ack N+2 (N+3 with readback check).
// Backpressure: requesters hold req until their ack; new requests wait while busy.
module led_pio_arbiter
  import led_pio_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [1:0]                pio_address,
  output logic                      pio_chipselect,
  output logic                      pio_write_n,
  output logic [31:0]               pio_writedata,
  input  logic [31:0]               pio_readdata,
  output logic                      busy,
  output logic [2:0]                owner,
  output logic                      err,
  input  logic                      err_clr
);

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_owner;
  logic [DATA_W-1:0] r_data;
  logic [2:0]        w_winner;
  logic              w_valid;
  logic              w_grant;
  logic [DATA_W-1:0] w_sel_data;

  led_rr_select #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_select (
    .req    (req),
    .owner  (r_owner),
    .winner (w_winner),
    .valid  (w_valid)
  );

  // Route the winning requester's data slice toward the latch.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == 3'(i)) begin
        w_sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and PIO/ack outputs; arbitration only happens in IDLE.
  always_comb begin
    w_next         = r_state;
    w_grant        = 1'b0;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = '0;
    ack            = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_grant = 1'b1;
          w_next  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_writedata  = 32'(r_data);
`ifdef LED_PIO_ARB_VERIFY_EN
        w_next = ST_VERIFY;
`else
        w_next = ST_DONE;
`endif
      end
      ST_VERIFY: begin
`ifdef LED_PIO_ARB_VERIFY_EN
        pio_chipselect = 1'b1;
        pio_writedata  = 32'(r_data);
        w_next         = ST_DONE;
`else
        w_next = ST_IDLE;
`endif
      end
      ST_DONE: begin
        ack    = NUM_REQ'(1) << r_owner;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Latch owner and data at the grant; owner resets to the top index so requester 0 goes first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner <= 3'(NUM_REQ - 1);
      r_data  <= '0;
    end else if (w_grant) begin
      r_owner <= w_winner;
      r_data  <= w_sel_data;
    end
  end

`ifdef LED_PIO_ARB_VERIFY_EN
  logic r_err;
  logic w_unused_rd;

  // Sticky readback mismatch; a new mismatch beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_VERIFY) && (pio_readdata[DATA_W-1:0] != r_data)) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign err         = r_err;
  assign w_unused_rd = ^pio_readdata;
`else
  logic w_unused_rd;

  assign err         = 1'b0;
  assign w_unused_rd = ^{err_clr, pio_readdata};
`endif

  assign busy        = (r_state != ST_IDLE);
  assign owner       = r_owner;
  assign pio_address = PIO_DATA_ADDR;

endmodule

// File: doc/led_pio_arbiter.md
LED_PIO_ARBITER -- requirements
Module: led_pio_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter DATA_W, default 8, SHALL set the LED data width (1..32).
REQ-003 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req  input  NUM_REQ  SHALL be per-requester write requests, held high until the matching ack.
REQ-006 req_data  input  NUM_REQ*DATA_W  SHALL carry requester i's LED value in slice [i*DATA_W +: DATA_W].
REQ-007 ack  output  NUM_REQ  SHALL pulse one cycle when requester i's transaction completes.
REQ-008 pio_address  output  2  SHALL be the PIO slave address, constant 0.
REQ-009 pio_chipselect  output  1  SHALL be the PIO slave select.
REQ-010 pio_write_n  output  1  SHALL be the PIO active-low write strobe.
REQ-011 pio_writedata  output  32  SHALL carry the latched value, zero-extended from DATA_W.
REQ-012 pio_readdata  input  32  SHALL be the PIO read data (combinational in slave); used only under REQ-030.
REQ-013 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-014 owner  output  3  SHALL hold the index of the last granted requester.
REQ-015 err  output  1  SHALL be the sticky readback-mismatch flag.
REQ-016 err_clr  input  1  SHALL clear err synchronously.

Function
REQ-017 FSM states SHALL be IDLE, WRITE, VERIFY (macro only), DONE.
REQ-018 IDLE: if any req bit is high, the winner SHALL be the first set bit searching upward from owner+1 modulo NUM_REQ; its data SHALL be latched, owner SHALL be updated, and the FSM SHALL go to WRITE; otherwise stay.
REQ-019 WRITE (one cycle): pio_chipselect=1, pio_write_n=0, pio_writedata=latched value; next state VERIFY if enabled, else DONE.
REQ-020 DONE (one cycle): ack[owner]=1, then IDLE; new arbitration SHALL NOT occur in DONE.
REQ-021 Outside WRITE/VERIFY: pio_chipselect=0, pio_write_n=1, pio_writedata=0.
REQ-022 Latency: req sampled in IDLE at cycle N -> write strobe at N+1 -> ack at N+2 (N+3 with verify).
REQ-023 Requests arriving while busy SHALL wait; none SHALL be lost if held.
REQ-024 req dropped mid-transaction: transaction SHALL complete and ack SHALL still pulse.
REQ-025 All requesters continuously active: grants SHALL rotate 0,1,...,NUM_REQ-1,0 with one grant per transaction.
REQ-026 At most one ack bit SHALL be high in any cycle.
REQ-027 err_clr coincident with a new mismatch: set SHALL win.

Reset
REQ-028 On reset_n low: FSM=IDLE, owner=NUM_REQ-1, latched data=0, ack=0, busy=0, err=0, pio_chipselect=0, pio_write_n=1, pio_writedata=0, pio_address=0.
REQ-029 Reset mid-transaction SHALL abort without any ack; first grant after reset SHALL go to requester 0 if requesting.

Configuration
REQ-030 With LED_PIO_ARB_VERIFY_EN defined: VERIFY (one cycle) SHALL drive pio_chipselect=1, pio_write_n=1, address 0; it SHALL compare pio_readdata[DATA_W-1:0] with the latched value and set err on mismatch.
REQ-031 Without LED_PIO_ARB_VERIFY_EN: no VERIFY state, err tied 0, err_clr and pio_readdata ignored.

Structure
REQ-032 FSM state encoding and the PIO data-register address constant (0) SHALL live in shared package led_pio_pkg.
REQ-033 Round-robin winner selection SHALL be sub-module led_rr_select (inputs req, owner; output winner index, valid).

Verification
REQ-034 Single req[2]=1, data 0xA5 -> at N+1 chipselect=1, write_n=0, writedata=0x000000A5; ack=4'b0100 at N+2.
REQ-035 req=4'b1111 held -> acks in order 0,1,2,3,0; each ack 3 cycles apart (4 with verify).
REQ-036 req[1] dropped during WRITE -> ack[1] still pulses; no further grant to 1.
REQ-037 reset_n low during WRITE -> no ack; outputs at reset values; then req=4'b1010 -> requester 1 granted first.
REQ-038 Verify build, pio_readdata forced 0x00 while writing 0x3C -> err=1 after VERIFY; err_clr pulse -> err=0.
